nibble_serial_adder: RTL and testbench

Multi-cycle W-bit adder that sits directly upstream of a 4-bit ripple-carry slice and drives it. It accepts wide operands over a valid/ready handshake. It then feeds the slice one nibble per clock, LSB nibble first, chaining each nibble's carry-out into the next nibble's carry-in through a register. It presents the registered sum, carry-out and signed overflow to a downstream consumer over a second valid/ready handshake.

---
 rtl/nsa_pkg.sv | 18 +
 rtl/nibble_serial_adder_if.sv | 32 +++
 rtl/rca4_slice.sv | 29 ++
 rtl/nibble_serial_adder.sv | 105 ++++++++++
 tb/tb_nibble_serial_adder.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder: FSM state encoding,
// slice width and the counter-width helper.
package nsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIBBLE_W = 4;

  // A lone nibble still needs a 1-bit counter so the compare logic stays uniform.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand (in_*) and result (out_*) handshakes of the nibble-serial adder.
// The slave modport is the adder side; master is the producer/consumer side.
interface nibble_serial_adder_if
  import nsa_pkg::*;
#(
  parameter int NIBBLES = 4
);
  localparam int W = NIBBLE_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

endinterface

// File: rtl/rca4_slice.sv
// Combinational 4-bit ripple-carry slice; exposes the carry into bit 3 as well
// as the carry out so the caller can derive signed overflow.
module rca4_slice
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                c3,
  output logic                c4
);

  logic [NIBBLE_W:0] w_c;

  assign w_c[0] = ci;

  genvar gi;
  generate
    for (gi = 0; gi < NIBBLE_W; gi++) begin : g_fa
      assign s[gi]       = a[gi] ^ b[gi] ^ w_c[gi];
      assign w_c[gi + 1] = (a[gi] & b[gi]) | (a[gi] & w_c[gi]) | (b[gi] & w_c[gi]);
    end
  endgenerate

  assign c3 = w_c[NIBBLE_W - 1];
  assign c4 = w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// W-bit adder that reuses one 4-bit ripple slice over NIBBLES cycles, LSB first,
// with the inter-nibble carry held in a register.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_adder_if.slave  bus
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = cnt_width(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  state_e           r_state;
  logic [W-1:0]     r_a_sh;
  logic [W-1:0]     r_b_sh;
  logic [W-1:0]     r_sum_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_valid;

  logic [NIBBLE_W-1:0] w_s;
  logic                w_c3;
  logic                w_c4;
  logic [W-1:0]        w_sum_sh_next;

  rca4_slice u_slice (
    .a  (r_a_sh[NIBBLE_W-1:0]),
    .b  (r_b_sh[NIBBLE_W-1:0]),
    .ci (r_carry),
    .s  (w_s),
    .c3 (w_c3),
    .c4 (w_c4)
  );

  // New nibble enters at the top so that after NIBBLES shifts the LSB nibble
  // has reached bit 0; written with shifts so NIBBLES=1 needs no special case.
  assign w_sum_sh_next = (r_sum_sh >> NIBBLE_W) | (W'(w_s) << (W - NIBBLE_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_sum_sh    <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a_sh   <= bus.a;
            r_b_sh   <= bus.b;
            r_sum_sh <= '0;
            r_carry  <= bus.cin;
            r_cnt    <= '0;
            r_state  <= ADD;
          end
        end
        ADD: begin
          r_a_sh   <= r_a_sh >> NIBBLE_W;
          r_b_sh   <= r_b_sh >> NIBBLE_W;
          r_sum_sh <= w_sum_sh_next;
          r_carry  <= w_c4;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_sum       <= w_sum_sh_next;
            r_cout      <= w_c4;
            r_ovf       <= w_c3 ^ w_c4;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4): vector table plus
// hand-written backpressure, ignore and abort sequences, scoreboard-checked.
module tb_nibble_serial_adder;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic clk;
  logic rst_n;

  nibble_serial_adder_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  res_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one operation; stall = cycles of out_ready=0 in DONE, poke = drive a
  // stray in_valid with 0x1111 operands throughout ADD and DONE.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic [W-1:0] es, input logic ec, input logic eo,
                       input int stall, input bit poke);
    int   lat;
    res_t exp_r;
    res_t got_r;
    logic [W-1:0] h_sum;
    logic h_cout, h_ovf;
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.a = a; bus.b = b; bus.cin = cin; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    sb_q.push_back('{sum: es, cout: ec, ovf: eo});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (poke) begin
      bus.in_valid = 1'b1; bus.a = 16'h1111; bus.b = 16'h1111; bus.cin = 1'b1;
    end
    chk("busy_after_accept", {30'd0, bus.busy, bus.in_ready}, 32'b10);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!bus.out_valid && lat < 20);
    chk("latency", 32'(lat), 32'(NIBBLES));
    h_sum = bus.sum; h_cout = bus.cout; h_ovf = bus.ovf;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_stable", {14'd0, bus.sum, bus.cout, bus.ovf},
          {14'd0, h_sum, h_cout, h_ovf});
      chk("stall_flags", {29'd0, bus.out_valid, bus.in_ready, bus.busy}, 32'b101);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      exp_r = sb_q.pop_front();
      got_r = '{sum: bus.sum, cout: bus.cout, ovf: bus.ovf};
      chk("sum", 32'(got_r.sum), 32'(exp_r.sum));
      chk("cout_ovf", {30'd0, got_r.cout, got_r.ovf}, {30'd0, exp_r.cout, exp_r.ovf});
    end
    $display("op %h + %h + %0d -> sum=%h cout=%0d ovf=%0d lat=%0d stall=%0d",
             a, b, cin, bus.sum, bus.cout, bus.ovf, lat, stall);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("post_handshake", {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
  endtask

  vec_t vecs[10];

  initial begin
    bit seen_valid;
    vecs[0] = '{16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[2] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0};
    vecs[3] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[9] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_flags", {29'd0, bus.in_ready, bus.busy, bus.out_valid}, 32'b100);
    chk("reset_result", {14'd0, bus.sum, bus.cout, bus.ovf}, 32'd0);

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin,
            vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf, 0, 1'b0);

    // Backpressure with a stray in_valid during ADD and DONE, then next op.
    do_op(16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0, 5, 1'b1);
    do_op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 0, 1'b0);

    // Abort two nibbles into an operation with an asynchronous reset.
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h1111; bus.cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_flags", {29'd0, bus.in_ready, bus.busy, bus.out_valid}, 32'b100);
    chk("abort_result", {14'd0, bus.sum, bus.cout, bus.ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < NIBBLES + 4; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen_valid = 1'b1;
    end
    chk("abort_no_result", {31'd0, seen_valid}, 32'd0);
    $display("op 1234 + 1111 aborted after 2 nibbles, out_valid seen=%0d", seen_valid);
    do_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
